// File: rtl/rfid_seq_tx.sv
// Message sequencer for a UART-style serial line: a buffered message of
// DATA_BITS-wide characters is framed and shifted out on baud_tick strobes.
module rfid_seq_tx #(
   parameter int DATA_BITS   = 8,
   parameter int DEPTH       = 16,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_MODE = 0
) (
   input  logic                     clk_24M,
   input  logic                     rst,
   input  logic                     baud_tick,
   input  logic                     rx_int,
   input  logic                     start,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_BITS-1:0]     wr_data,
   input  logic [$clog2(DEPTH):0]   msg_len,
   output logic                     txd,
   output logic                     busy,
   output logic                     done
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;

   logic                 rx_s1, rx_s2, rx_h;
   logic [1:0]           settle;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [DATA_BITS-1:0] shreg;
   logic                 par_q;
   logic [AW-1:0]        char_idx;
   logic [LW-1:0]        len_q;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic                 fall, accept, last_bit, last_stop, more;

   // The chain resets high, so an rx_int held low through reset would look
   // like a falling edge; edges are ignored until the chain has refilled.
   assign fall      = rx_h & ~rx_s2 & (settle == 2'd3);
   assign accept    = (state == IDLE) & (fall | start) & (msg_len != '0);
   assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
   assign last_stop = (32'(stop_cnt) == STOP_BITS - 1);
   assign more      = ({1'b0, char_idx} + LW'(1)) < len_q;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         rx_s1  <= 1'b1;
         rx_s2  <= 1'b1;
         rx_h   <= 1'b1;
         settle <= 2'd0;
      end else begin
         rx_s1 <= rx_int;
         rx_s2 <= rx_s1;
         rx_h  <= rx_s2;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !busy) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ARM;
         ARM:     if (baud_tick) state_nx = START;
         START:   if (baud_tick) state_nx = DATA;
         DATA:    if (baud_tick && last_bit)
                     state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:  if (baud_tick) state_nx = STOP;
         STOP:    if (baud_tick && last_stop) state_nx = more ? START : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         txd      <= 1'b1;
         done     <= 1'b0;
         shreg    <= '0;
         par_q    <= 1'b0;
         char_idx <= '0;
         len_q    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            len_q    <= (msg_len > LW'(DEPTH)) ? LW'(DEPTH) : msg_len;
            char_idx <= '0;
         end
         if (baud_tick) begin
            case (state)
               ARM: begin
                  txd   <= 1'b0;
                  shreg <= mem[char_idx];
                  par_q <= (^mem[char_idx]) ^ (PARITY_MODE == 2);
               end
               START: begin
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
               end
               DATA: begin
                  if (!last_bit) begin
                     txd     <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + BW'(1);
                  end else if (PARITY_MODE != 0) begin
                     txd <= par_q;
                  end else begin
                     txd      <= 1'b1;
                     stop_cnt <= 1'b0;
                  end
               end
               PARITY: begin
                  txd      <= 1'b1;
                  stop_cnt <= 1'b0;
               end
               STOP: begin
                  if (!last_stop) begin
                     stop_cnt <= 1'b1;
                  end else if (more) begin
                     // back-to-back: next start bit begins on this same tick
                     char_idx <= char_idx + AW'(1);
                     txd      <= 1'b0;
                     shreg    <= mem[char_idx + AW'(1)];
                     par_q    <= (^mem[char_idx + AW'(1)]) ^ (PARITY_MODE == 2);
                  end else begin
                     done     <= 1'b1;
                     char_idx <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rfid_seq_tx.sv
// Bench for rfid_seq_tx: four parameter variants share stimulus and are
// checked tick by tick against frames built from the buffer contents.
module tb_rfid_seq_tx;
   localparam int NI    = 4;
   localparam int DEPTH = 16;
   localparam int MAXB  = DEPTH * 12;

   logic          clk_24M = 1'b0;
   logic          rst, baud_tick, rx_int, start, wr_en;
   logic [3:0]    wr_addr;
   logic [7:0]    wr_data;
   logic [4:0]    msg_len;
   logic [NI-1:0] txd_v, busy_v, done_v;

   int   n_chk = 0;
   int   n_fail = 0;
   int   done_cnt [NI] = '{default: 0};
   int   snap [NI];
   logic [7:0] mdl_mem [DEPTH];
   logic exp_bits [NI][MAXB];
   int   tlen [NI];

   always #5 clk_24M = ~clk_24M;

   rfid_seq_tx #(.PARITY_MODE(0)) u0 (.clk_24M(clk_24M), .rst(rst), .baud_tick(baud_tick),
      .rx_int(rx_int), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   rfid_seq_tx #(.PARITY_MODE(1)) u1 (.clk_24M(clk_24M), .rst(rst), .baud_tick(baud_tick),
      .rx_int(rx_int), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   rfid_seq_tx #(.PARITY_MODE(2)) u2 (.clk_24M(clk_24M), .rst(rst), .baud_tick(baud_tick),
      .rx_int(rx_int), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));
   rfid_seq_tx #(.STOP_BITS(2)) u3 (.clk_24M(clk_24M), .rst(rst), .baud_tick(baud_tick),
      .rx_int(rx_int), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .txd(txd_v[3]), .busy(busy_v[3]), .done(done_v[3]));

   always @(posedge clk_24M)
      for (int k = 0; k < NI; k++) if (done_v[k] === 1'b1) done_cnt[k]++;

   function automatic int pm_of(input int k);
      return (k == 1) ? 1 : (k == 2) ? 2 : 0;
   endfunction

   function automatic int sb_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line levels, one per bit period, for a whole message.
   task automatic build(input int len);
      for (int k = 0; k < NI; k++) begin
         int p = 0;
         for (int c = 0; c < len; c++) begin
            logic [7:0] ch = mdl_mem[c];
            int ones = 0;
            exp_bits[k][p++] = 1'b0;
            for (int b = 0; b < 8; b++) begin
               exp_bits[k][p++] = ch[b];
               ones += int'(ch[b]);
            end
            if (pm_of(k) == 1) exp_bits[k][p++] = (ones % 2 == 1);
            if (pm_of(k) == 2) exp_bits[k][p++] = (ones % 2 == 0);
            for (int s = 0; s < sb_of(k); s++) exp_bits[k][p++] = 1'b1;
         end
         tlen[k] = p;
      end
   endtask

   task automatic tick();
      baud_tick = 1'b1;
      @(negedge clk_24M);
      baud_tick = 1'b0;
   endtask

   task automatic write_buf(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      @(negedge clk_24M);
      wr_en = 1'b0;
      mdl_mem[a] = d;
   endtask

   task automatic trig_start(input bit coincide);
      start = 1'b1; baud_tick = coincide;
      @(negedge clk_24M);
      start = 1'b0; baud_tick = 1'b0;
      chk("trig_busy", busy_v, 4'hF);
      chk("arm_txd", txd_v, 4'hF);
   endtask

   task automatic trig_rx();
      int w = 0;
      rx_int = 1'b0;
      while (busy_v !== 4'hF && w < 8) begin
         @(negedge clk_24M);
         w++;
      end
      chk("rx_trig_busy", busy_v, 4'hF);
      chk("rx_arm_txd", txd_v, 4'hF);
      rx_int = 1'b1;
   endtask

   task automatic run_msg(input int len_req, input bit disturb);
      int L, nmax, g;
      int dc0 [NI];
      logic [NI-1:0] last;
      L = (len_req > DEPTH) ? DEPTH : len_req;
      build(L);
      nmax = 0;
      for (int k = 0; k < NI; k++) begin
         if (tlen[k] > nmax) nmax = tlen[k];
         dc0[k] = done_cnt[k];
      end
      nmax += 2;
      for (int n = 1; n <= nmax; n++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            if (n <= tlen[k]) begin
               chk($sformatf("txd u%0d tick%0d", k, n), txd_v[k], exp_bits[k][n-1]);
               chk($sformatf("busy u%0d tick%0d", k, n), busy_v[k], 1);
               chk($sformatf("done u%0d tick%0d", k, n), done_v[k], 0);
            end else if (n == tlen[k] + 1) begin
               chk($sformatf("end_txd u%0d", k), txd_v[k], 1);
               chk($sformatf("end_busy u%0d", k), busy_v[k], 0);
               chk($sformatf("end_done u%0d", k), done_v[k], 1);
            end else begin
               chk($sformatf("post_txd u%0d", k), txd_v[k], 1);
               chk($sformatf("post_busy u%0d", k), busy_v[k], 0);
            end
         end
         last = txd_v;
         if (disturb && n == 3) begin
            start = 1'b1;
            @(negedge clk_24M);
            start = 1'b0; rx_int = 1'b0;
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~mdl_mem[0];
            msg_len = 5'($urandom_range(0, 31));
            @(negedge clk_24M);
            wr_en = 1'b0;
            chk("disturb_txd_hold", txd_v, last);
         end
         if (disturb && n == 6) rx_int = 1'b1;
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(negedge clk_24M);
            chk("txd_hold", txd_v, last);
         end
      end
      for (int k = 0; k < NI; k++)
         chk($sformatf("done_count u%0d", k), done_cnt[k] - dc0[k], 1);
   endtask

   initial begin
      rst = 1'b0; baud_tick = 1'b0; rx_int = 1'b1; start = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
      repeat (3) @(negedge clk_24M);
      chk("rst_txd", txd_v, 4'hF);
      chk("rst_busy", busy_v, 4'h0);
      chk("rst_done", done_v, 4'h0);
      rst = 1'b1;
      @(negedge clk_24M);

      write_buf(0, 8'h55); msg_len = 5'd1;
      trig_start(1'b0); run_msg(1, 1'b0);

      // trigger coincident with a tick must not advance past ARM
      write_buf(0, 8'h07);
      trig_start(1'b1); run_msg(1, 1'b0);

      write_buf(0, 8'hA0); write_buf(1, 8'h0F); write_buf(2, 8'hFF);
      msg_len = 5'd3;
      trig_start(1'b0); run_msg(3, 1'b1);
      msg_len = 5'd3;
      trig_rx(); run_msg(3, 1'b0);

      for (int it = 0; it < 3; it++) begin
         int L = $urandom_range(1, 5);
         for (int c = 0; c < L; c++) write_buf(c, 8'($urandom));
         msg_len = 5'(L);
         if ($urandom_range(0, 1) == 1) trig_rx();
         else trig_start(1'($urandom_range(0, 1)));
         run_msg(L, 1'b0);
      end

      msg_len = 5'd0;
      snap = done_cnt;
      start = 1'b1;
      @(negedge clk_24M);
      start = 1'b0; rx_int = 1'b0;
      repeat (4) begin
         tick();
         chk("len0_busy", busy_v, 4'h0);
         chk("len0_txd", txd_v, 4'hF);
      end
      rx_int = 1'b1;
      repeat (4) @(negedge clk_24M);
      for (int k = 0; k < NI; k++) chk("len0_done", done_cnt[k] - snap[k], 0);

      // reset in the middle of data bit 4, rx_int held low across it
      write_buf(0, 8'($urandom)); msg_len = 5'd1;
      trig_start(1'b0);
      repeat (6) tick();
      for (int k = 0; k < NI; k++) chk("pre_rst_bit4", txd_v[k], mdl_mem[0][4]);
      rx_int = 1'b0; rst = 1'b0;
      #1;
      chk("async_rst_txd", txd_v, 4'hF);
      chk("async_rst_busy", busy_v, 4'h0);
      chk("async_rst_done", done_v, 4'h0);
      repeat (2) @(negedge clk_24M);
      rst = 1'b1;
      repeat (6) @(negedge clk_24M);
      chk("no_false_edge", busy_v, 4'h0);
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
      msg_len = 5'd1;
      trig_start(1'b0); run_msg(1, 1'b0);
      rx_int = 1'b1;
      repeat (4) @(negedge clk_24M);
      chk("rise_no_trig", busy_v, 4'h0);
      write_buf(0, 8'($urandom)); write_buf(1, 8'($urandom));
      msg_len = 5'd2;
      trig_rx(); run_msg(2, 1'b0);

      for (int c = 0; c < DEPTH; c++) write_buf(c, 8'($urandom));
      msg_len = 5'(DEPTH + 5);
      trig_start(1'b0); run_msg(DEPTH + 5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rfid_seq_tx.md
RFID_SEQ_TX -- requirements
Module: rfid_seq_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per character (5..8), sent LSB first.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning message buffer entries (2..64).
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per character (1 or 2).
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL have port clk_24M, input, 1 bit: system clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port baud_tick, input, 1 bit: one-cycle bit-period strobe.
REQ-008 The block SHALL have port rx_int, input, 1 bit: asynchronous external trigger; a falling edge requests transmission.
REQ-009 The block SHALL have port start, input, 1 bit: synchronous one-cycle trigger, equivalent to an rx_int falling edge.
REQ-010 The block SHALL have port wr_en, input, 1 bit: buffer write strobe.
REQ-011 The block SHALL have port wr_addr, input, clog2(DEPTH) bits: buffer write index.
REQ-012 The block SHALL have port wr_data, input, DATA_BITS bits: buffer write data.
REQ-013 The block SHALL have port msg_len, input, clog2(DEPTH)+1 bits: number of characters to send.
REQ-014 The block SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-015 The block SHALL have port busy, output, 1 bit: high from trigger acceptance until the last stop bit ends.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when a message completes.

Function
REQ-017 rx_int SHALL pass through a 2-flop synchroniser plus 1 history flop; a falling edge SHALL be detected when the synchronised value is 0 and the history value is 1.
REQ-018 Trigger = detected edge OR start; triggers SHALL be ignored while busy = 1 or when the sampled msg_len = 0.
REQ-019 msg_len SHALL be sampled on trigger acceptance, and values > DEPTH SHALL be clamped to DEPTH.
REQ-020 wr_en SHALL write wr_data to buffer[wr_addr] only when busy = 0; writes while busy = 1 SHALL be dropped.
REQ-021 FSM states SHALL be IDLE, ARM, START, DATA, PARITY, STOP. IDLE->ARM on an accepted trigger (busy = 1 next cycle). All other transitions SHALL occur only on cycles where baud_tick = 1.
REQ-022 ARM->START: on baud_tick, drive txd = 0 and latch buffer[char_idx] into the shift register.
REQ-023 START->DATA: on baud_tick, drive data bit 0. Each subsequent baud_tick SHALL drive the next bit, through bit DATA_BITS-1.
REQ-024 DATA->PARITY when PARITY_MODE != 0. The parity bit SHALL be the XOR of the data bits (even) or its inverse (odd).
REQ-025 PARITY or DATA->STOP: drive txd = 1 for STOP_BITS baud periods.
REQ-026 At the end of the last stop period, if char_idx+1 < msg_len: increment char_idx, go to START, and drive the start bit on that same tick (no extra idle gap).
REQ-027 Otherwise the FSM SHALL go to IDLE, with busy = 0 and done = 1 for exactly one cycle on that tick.
REQ-028 txd SHALL be 1 in IDLE and ARM. txd SHALL be registered and change only on baud_tick cycles or on reset.
REQ-029 A baud_tick coincident with trigger acceptance SHALL NOT advance ARM; ARM waits for the next baud_tick.
REQ-030 Frame length per character SHALL be 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS baud periods.

Reset
REQ-031 On rst = 0 the block SHALL immediately force txd = 1, busy = 0, done = 0, state = IDLE, char_idx = 0, synchroniser flops = 1, and buffer contents = 0, including mid-frame.
REQ-032 After reset release, the first trigger SHALL be honoured normally, and no false edge SHALL be detected if rx_int is held low through reset.

Verification
REQ-033 Defaults: write buffer[0] = 0x55, msg_len = 1, start pulse -> txd per tick 0,1,0,1,0,1,0,1,0,1 -> busy drops and done pulses once on the stop-end tick.
REQ-034 PARITY_MODE = 1: send 0x07 -> parity bit 1. PARITY_MODE = 2: send 0x07 -> parity bit 0. Each frame is 11 ticks.
REQ-035 msg_len = 3 with buffer {0xA0, 0x0F, 0xFF}, STOP_BITS = 2 -> 33 contiguous ticks, start bits at tick offsets 0, 11, 22, and one done pulse.
REQ-036 rx_int falling edge during busy, start pulse during busy, msg_len = 0 trigger, and wr_en during busy -> no restart, no done, buffer unchanged.
REQ-037 rst asserted at data bit 4 -> txd = 1 asynchronously and busy = 0. After release, a fresh trigger sends the full frame from char 0.
REQ-038 msg_len = DEPTH + 5 -> exactly DEPTH characters sent, followed by a single done pulse.
